// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One result bit per RUN cycle, sign fix-up and write-back in a FIX cycle.
//
// state | meaning
// IDLE  | ready for an operation; MTHI/MTLO direct writes allowed
// RUN   | one shift-add or restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO write-back, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             op_q, op_d;
  logic                   sign_a_q, sign_a_d;
  logic                   sign_b_q, sign_b_d;
  logic [WIDTH-1:0]       a_mag_q, a_mag_d;
  logic [WIDTH-1:0]       b_mag_q, b_mag_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;

  logic [WIDTH-1:0]       a_mag_in, b_mag_in;
  logic [WIDTH:0]         msum;
  logic [WIDTH:0]         rem_sh;
  logic                   q_bit;
  logic [WIDTH-1:0]       rem_next;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix, rem_fix;
  logic                   neg_res;

  assign ready_o = (state_q == IDLE);
  assign busy_o  = ~ready_o;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    a_mag_in = (op_i[0] && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag_in = (op_i[0] && b_i[WIDTH-1]) ? -b_i : b_i;

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);

    // Divide: low half of acc shifts the dividend out and the quotient in.
    rem_sh   = {rem_q, acc_q[WIDTH-1]};
    q_bit    = (rem_sh >= {1'b0, b_mag_q});
    rem_next = q_bit ? WIDTH'(rem_sh - {1'b0, b_mag_q}) : rem_sh[WIDTH-1:0];

    neg_res  = op_q[0] && (sign_a_q ^ sign_b_q);
    prod_fix = neg_res ? -acc_q : acc_q;
    quo_fix  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = (op_q[0] && sign_a_q) ? -rem_q : rem_q;
    if (b_mag_q == '0) quo_fix = '1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (valid_i && !flush_i) begin
          state_d  = RUN;
          cnt_d    = '0;
          op_d     = op_i;
          sign_a_d = op_i[0] & a_i[WIDTH-1];
          sign_b_d = op_i[0] & b_i[WIDTH-1];
          a_mag_d  = a_mag_in;
          b_mag_d  = b_mag_in;
          rem_d    = '0;
          acc_d    = op_i[1] ? {{WIDTH{1'b0}}, a_mag_in} : {{WIDTH{1'b0}}, b_mag_in};
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (op_q[1]) begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
            rem_d = rem_next;
          end else begin
            acc_d = {msum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and reference-model checks of muldiv_unit at WIDTH 32 and 8.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;

  logic        v32 = 0, hwe32 = 0, lwe32 = 0, fl32 = 0;
  logic [1:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, wd32 = 0;
  logic        rdy32, busy32, done32;
  logic [31:0] hi32, lo32;

  logic        v8 = 0, hwe8 = 0, lwe8 = 0, fl8 = 0;
  logic [1:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, wd8 = 0;
  logic        rdy8, busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(v32), .ready_o(rdy32), .op_i(op32),
    .a_i(a32), .b_i(b32), .hi_we_i(hwe32), .lo_we_i(lwe32), .wdata_i(wd32),
    .flush_i(fl32), .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(v8), .ready_o(rdy8), .op_i(op8),
    .a_i(a8), .b_i(b8), .hi_we_i(hwe8), .lo_we_i(lwe8), .wdata_i(wd8),
    .flush_i(fl8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input bit sel8, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input string tag);
    int edges;
    if (sel8) begin
      chk({tag, "_ready"}, 64'(rdy8), 64'd1);
      v8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      chk({tag, "_ready"}, 64'(rdy32), 64'd1);
      v32 = 1; op32 = op; a32 = a; b32 = b;
    end
    @(negedge clk_i);
    v8 = 0; v32 = 0;
    chk({tag, "_busy"}, 64'(sel8 ? busy8 : busy32), 64'd1);
    edges = 0;
    while (!(sel8 ? done8 : done32) && edges < 60) begin
      @(negedge clk_i);
      edges++;
    end
    chk({tag, "_lat"}, 64'(edges), sel8 ? 64'd9 : 64'd33);
    chk({tag, "_hi"}, 64'(sel8 ? {24'd0, hi8} : hi32), 64'(ehi));
    chk({tag, "_lo"}, 64'(sel8 ? {24'd0, lo8} : lo32), 64'(elo));
  endtask

  function automatic logic [15:0] ref8(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    longint sa, sb, p, q, r;
    sa = op[0] ? longint'($signed(a)) : longint'(a);
    sb = op[0] ? longint'($signed(b)) : longint'(b);
    if (!op[1]) begin
      p = sa * sb;
      return p[15:0];
    end
    if (b == 8'd0) return {a, 8'hFF};
    q = sa / sb;
    r = sa % sb;
    return {r[7:0], q[7:0]};
  endfunction

  int done_seen;
  logic [15:0] exp8;
  logic [1:0]  rop;
  logic [7:0]  ra, rb;

  initial begin
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    chk("rst_hi", 64'(hi32), 64'd0);
    chk("rst_lo", 64'(lo32), 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_done", 64'(done32), 64'd0);

    run_op(0, 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult");
    run_op(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_b2b");
    @(negedge clk_i);
    chk("done_width", 64'(done32), 64'd0);
    run_op(0, 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    @(negedge clk_i);
    run_op(0, 2'b10, 32'd7, 32'd3, 32'd1, 32'd2, "divu");
    @(negedge clk_i);
    run_op(0, 2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu_zero");
    @(negedge clk_i);
    run_op(0, 2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_zero");
    @(negedge clk_i);
    run_op(0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div_ovf");
    @(negedge clk_i);

    // Direct writes, then a flushed divide must leave HI/LO alone.
    hwe32 = 1; lwe32 = 1; wd32 = 32'h11;
    @(negedge clk_i);
    lwe32 = 0; hwe32 = 0;
    chk("mthi_both", 64'(hi32), 64'h11);
    lwe32 = 1; wd32 = 32'h22;
    @(negedge clk_i);
    lwe32 = 0;
    chk("mtlo", 64'(lo32), 64'h22);
    chk("mtlo_hi_kept", 64'(hi32), 64'h11);

    v32 = 1; op32 = 2'b10; a32 = 32'd100; b32 = 32'd7;
    @(negedge clk_i);
    v32 = 0;
    repeat (4) @(negedge clk_i);
    hwe32 = 1; wd32 = 32'hABCD;
    @(negedge clk_i);
    hwe32 = 0;
    chk("mthi_busy", 64'(hi32), 64'h11);
    repeat (4) @(negedge clk_i);
    fl32 = 1;
    @(negedge clk_i);
    fl32 = 0;
    chk("flush_ready", 64'(rdy32), 64'd1);
    chk("flush_hi", 64'(hi32), 64'h11);
    chk("flush_lo", 64'(lo32), 64'h22);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done32) done_seen++;
    end
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("flush_hi_late", 64'(hi32), 64'h11);
    hwe32 = 1; wd32 = 32'hABCD;
    @(negedge clk_i);
    hwe32 = 0;
    chk("mthi_idle", 64'(hi32), 64'hABCD);
    chk("mthi_lo_kept", 64'(lo32), 64'h22);

    // WIDTH = 8 instance
    run_op(1, 2'b01, 32'hFD, 32'd5, 32'hFF, 32'hF1, "mult8");
    @(negedge clk_i);
    run_op(1, 2'b11, 32'hF9, 32'd2, 32'hFF, 32'hFD, "div8");
    @(negedge clk_i);
    run_op(1, 2'b11, 32'h80, 32'hFF, 32'h00, 32'h80, "div8_ovf");
    @(negedge clk_i);
    run_op(1, 2'b00, 32'hFF, 32'hFF, 32'hFE, 32'h01, "multu8");
    @(negedge clk_i);
    for (int i = 0; i < 24; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      exp8 = ref8(rop, ra, rb);
      run_op(1, rop, {24'd0, ra}, {24'd0, rb}, {24'd0, exp8[15:8]}, {24'd0, exp8[7:0]}, "rnd8");
      @(negedge clk_i);
    end

    // Reset in the middle of a multiply
    v32 = 1; op32 = 2'b00; a32 = 32'd3; b32 = 32'd5;
    @(negedge clk_i);
    v32 = 0;
    repeat (5) @(negedge clk_i);
    rst_i = 0;
    #1;
    chk("mrst_hi", 64'(hi32), 64'd0);
    chk("mrst_lo", 64'(lo32), 64'd0);
    chk("mrst_ready", 64'(rdy32), 64'd1);
    @(negedge clk_i);
    rst_i = 1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done32) done_seen++;
    end
    chk("mrst_no_done", 64'(done_seen), 64'd0);
    chk("mrst_ready_late", 64'(rdy32), 64'd1);
    chk("mrst_lo_late", 64'(lo32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
